// File: rtl/mips_irq_pkg.sv
// Shared types and constants for the interrupt controller: FSM encoding,
// default geometry and vector table layout.
package mips_irq_pkg;

    localparam int          NUM_IRQ_DEF  = 4;
    localparam logic [15:0] VEC_BASE_DEF = 16'h00F0;
    localparam int          VEC_STRIDE   = 4;
    localparam int          IRQ_ID_W     = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder over the eligible set; index 0 wins.
module irq_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     elig,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        valid = |elig;
        idx   = '0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (elig[i]) idx = i[IDX_W-1:0];
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered, fixed-priority, non-nesting interrupt controller producing
// a one-cycle request pulse and a registered vector address.
module interrupt_controller
    import mips_irq_pkg::*;
#(
    parameter int          NUM_IRQ  = NUM_IRQ_DEF,
    parameter logic [15:0] VEC_BASE = VEC_BASE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               cfg_we,
    input  logic [NUM_IRQ-1:0] cfg_data,
    input  logic               hold_off,
    input  logic               eoi,
    output logic               interrupt,
    output logic [1:0]         irq_id,
    output logic [15:0]        vec_addr,
    output logic               busy,
    output logic [NUM_IRQ-1:0] pending
);

    irq_state_t            state;
    logic [NUM_IRQ-1:0]    irq_prev;
    logic [NUM_IRQ-1:0]    irq_en;
    logic [NUM_IRQ-1:0]    irq_evt;
    logic [NUM_IRQ-1:0]    clr_mask;
    logic                  enc_valid;
    logic [IRQ_ID_W-1:0]   enc_idx;
    logic                  dispatch;

    assign irq_evt  = irq_in & ~irq_prev;
    assign dispatch = (state == IDLE) && enc_valid && !hold_off;

    irq_prio_enc #(
        .N     (NUM_IRQ),
        .IDX_W (IRQ_ID_W)
    ) u_prio (
        .elig  (pending & irq_en),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    always_comb begin
        clr_mask = '0;
        if (dispatch) clr_mask[enc_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            interrupt <= 1'b0;
            busy      <= 1'b0;
            irq_id    <= '0;
            vec_addr  <= VEC_BASE;
            pending   <= '0;
            irq_en    <= '0;
            // Lines already high at reset are not treated as new events.
            irq_prev  <= irq_in;
        end else begin
            irq_prev <= irq_in;
            if (cfg_we) irq_en <= cfg_data;
            // New events are OR-ed after the clear so a same-edge re-rise survives.
            pending <= (pending & ~clr_mask) | irq_evt;

            case (state)
                IDLE: begin
                    if (dispatch) begin
                        state     <= ASSERT;
                        interrupt <= 1'b1;
                        busy      <= 1'b1;
                        irq_id    <= enc_idx;
                        vec_addr  <= VEC_BASE + 16'(enc_idx) * 16'(VEC_STRIDE);
                    end
                end
                ASSERT: begin
                    state     <= SERVICE;
                    interrupt <= 1'b0;
                end
                SERVICE: begin
                    if (eoi) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    interrupt <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with hand-computed expectations.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_in;
    logic        cfg_we;
    logic [3:0]  cfg_data;
    logic        hold_off;
    logic        eoi;
    logic        interrupt;
    logic [1:0]  irq_id;
    logic [15:0] vec_addr;
    logic        busy;
    logic [3:0]  pending;

    int n_cmp = 0;
    int n_err = 0;

    interrupt_controller #(.NUM_IRQ(4), .VEC_BASE(16'h00F0)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .cfg_we    (cfg_we),
        .cfg_data  (cfg_data),
        .hold_off  (hold_off),
        .eoi       (eoi),
        .interrupt (interrupt),
        .irq_id    (irq_id),
        .vec_addr  (vec_addr),
        .busy      (busy),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so registered outputs can be sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [3:0] mask);
        cfg_we   = 1'b1;
        cfg_data = mask;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic end_service();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq_in = '0; cfg_we = 1'b0; cfg_data = '0;
        hold_off = 1'b0; eoi = 1'b0;
        tick();
        tick();
        chk("rst_interrupt", interrupt, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_irq_id",    irq_id,    0);
        chk("rst_vec",       vec_addr,  16'h00F0);
        chk("rst_pending",   pending,   0);
        reset = 1'b0;
        tick();

        // Basic dispatch of source 2
        cfg(4'b0100);
        irq_in = 4'b0100;
        tick();
        chk("basic_pend",      pending,   4'b0100);
        chk("basic_no_int",    interrupt, 0);
        tick();
        chk("basic_int",       interrupt, 1);
        chk("basic_id",        irq_id,    2);
        chk("basic_vec",       vec_addr,  16'h00F8);
        chk("basic_busy",      busy,      1);
        chk("basic_pend_clr",  pending,   0);
        tick();
        chk("basic_int_1cyc",  interrupt, 0);
        chk("basic_busy_svc",  busy,      1);
        cfg(4'b0000);
        tick();
        chk("mask_no_abort",   busy,      1);
        chk("basic_vec_hold",  vec_addr,  16'h00F8);
        end_service();
        chk("basic_eoi_idle",  busy,      0);
        irq_in = '0;
        tick();

        // Priority: sources 1 and 3 together
        cfg(4'b1111);
        irq_in = 4'b1010;
        tick();
        chk("prio_pend",       pending,   4'b1010);
        tick();
        chk("prio_int1",       interrupt, 1);
        chk("prio_id1",        irq_id,    1);
        chk("prio_pend3",      pending,   4'b1000);
        tick();
        end_service();
        chk("prio_idle",       busy,      0);
        tick();
        chk("prio_int3",       interrupt, 1);
        chk("prio_id3",        irq_id,    3);
        chk("prio_vec3",       vec_addr,  16'h00FC);
        tick();
        end_service();
        irq_in = '0;
        tick();

        // Hold-off delays dispatch of source 0
        hold_off = 1'b1;
        irq_in   = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_no_int", interrupt, 0);
        end
        chk("hold_pend",       pending,   4'b0001);
        hold_off = 1'b0;
        tick();
        chk("hold_int",        interrupt, 1);
        chk("hold_id",         irq_id,    0);
        chk("hold_vec",        vec_addr,  16'h00F0);
        tick();
        end_service();
        irq_in = '0;
        tick();

        // Masked pending, then enable
        cfg(4'b0000);
        irq_in = 4'b0010;
        tick();
        chk("mask_pend",       pending,   4'b0010);
        tick();
        tick();
        chk("mask_no_int",     interrupt, 0);
        chk("mask_not_busy",   busy,      0);
        cfg(4'b0010);
        chk("mask_cfg_edge",   interrupt, 0);
        tick();
        chk("mask_int",        interrupt, 1);
        chk("mask_id",         irq_id,    1);
        tick();
        end_service();
        irq_in = '0;
        tick();

        // Collision: re-rise of source 0 on its own dispatch edge
        cfg(4'b0001);
        hold_off = 1'b1;
        irq_in   = 4'b0001;
        tick();
        irq_in   = 4'b0000;
        tick();
        chk("coll_pend_pre",   pending,   4'b0001);
        irq_in   = 4'b0001;
        hold_off = 1'b0;
        tick();
        chk("coll_int",        interrupt, 1);
        chk("coll_set_wins",   pending,   4'b0001);
        tick();
        end_service();
        tick();
        chk("coll_redispatch", interrupt, 1);
        tick();
        tick();
        chk("rst_pre_busy",    busy,      1);

        // Reset mid-service overrides cfg_we, eoi and events; irq_in[0] stays high
        reset = 1'b1; cfg_we = 1'b1; cfg_data = 4'b1111; eoi = 1'b1;
        tick();
        reset = 1'b0; cfg_we = 1'b0; eoi = 1'b0;
        chk("rmid_busy",       busy,      0);
        chk("rmid_int",        interrupt, 0);
        chk("rmid_pend",       pending,   0);
        chk("rmid_vec",        vec_addr,  16'h00F0);
        chk("rmid_id",         irq_id,    0);
        tick();
        chk("rmid_no_evt",     pending,   0);
        end_service();
        chk("rmid_eoi_ign",    busy,      0);
        irq_in = 4'b1001;
        tick();
        chk("rmid_pend3",      pending,   4'b1000);
        tick();
        tick();
        chk("rmid_en_clear",   interrupt, 0);
        chk("rmid_en_busy",    busy,      0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
